// File: rtl/usb_tx_arbiter_pkg.sv
// Shared definitions for the USB transmit arbiter: FSM state encoding,
// source index constants and a one-hot decode helper.
package usb_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        WRITE  = 3'd2,
        WAIT1  = 3'd3,
        WAIT2  = 3'd4,
        DONE   = 3'd5,
        HOLD   = 3'd6
    } arb_state_e;

    localparam int SRC_CTRL_REGS = 0;
    localparam int SRC_SDI       = 1;
    localparam int SRC_CSI       = 2;

    // Index of the highest set bit of a one-hot vector (0 when empty).
    function automatic int unsigned onehot_index(input logic [31:0] onehot);
        int unsigned idx;
        idx = 32'd0;
        for (int k = 0; k < 32; k++) begin
            if (onehot[k]) begin
                idx = 32'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr,
// wrapping modulo N_SRC, returned as a one-hot grant.
module usb_rr_pick
    import usb_tx_arbiter_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int PW    = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_SRC-1:0] grant
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan the requesters in rotated order and keep the first hit.
    always_comb begin
        grant   = {N_SRC{1'b0}};
        found_s = 1'b0;
        sum_s   = (PW+1)'(0);
        idx_s   = PW'(0);
        for (int k = 0; k < N_SRC; k++) begin
            sum_s = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum_s >= (PW+1)'(N_SRC)) begin
                idx_s = PW'(sum_s - (PW+1)'(N_SRC));
            end else begin
                idx_s = PW'(sum_s);
            end
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter sharing the USB transmit FIFO between byte-stream
// packet sources, with stall and overlength supervision.
module usb_tx_arbiter
    import usb_tx_arbiter_pkg::*;
#(
    parameter int N_SRC     = 3,
    parameter int MAX_LEN   = 255,
    parameter int STALL_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [N_SRC-1:0]     src_req,
    input  logic [8*N_SRC-1:0]   src_q,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_rdreq,
    output logic [N_SRC-1:0]     src_done,
    input  logic                 usb_txe_n,
    output logic                 usb_wr,
    output logic [7:0]           usb_data,
    output logic                 busy,
    output logic [N_SRC-1:0]     grant,
    output logic                 stall_flag,
    output logic                 ovl_flag,
    input  logic                 flag_clr
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(STALL_CYC + 1);

    arb_state_e       state_r, state_s;
    logic [PW-1:0]    rr_ptr_r, gidx_s;
    logic [N_SRC-1:0] grant_r, pick_s, done_r;
    logic [7:0]       byte_r, mux_byte_s;
    logic             last_r, mux_last_s;
    logic [CW-1:0]    byte_cnt_r;
    logic [SW-1:0]    stall_cnt_r;
    logic             busy_r, stall_flag_r, ovl_flag_r;
    logic             wr_s, at_max_s, stall_set_s, ovl_set_s;

    usb_rr_pick #(
        .N_SRC (N_SRC),
        .PW    (PW)
    ) u_pick (
        .req    (src_req),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_s)
    );

    // Granted source's byte/last, captured in SETTLE and WAIT2 once the source has settled.
    always_comb begin
        mux_byte_s = 8'h00;
        mux_last_s = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            mux_byte_s = mux_byte_s | (src_q[8*i +: 8] & {8{grant_r[i]}});
            mux_last_s = mux_last_s | (src_last[i] & grant_r[i]);
        end
        gidx_s = PW'(onehot_index(32'(grant_r)));
    end

    // Next-state logic and the per-cycle write/flag events.
    always_comb begin
        state_s     = state_r;
        wr_s        = 1'b0;
        at_max_s    = (byte_cnt_r == CW'(MAX_LEN - 1));
        stall_set_s = (state_r == WRITE) && usb_txe_n && (stall_cnt_r == SW'(STALL_CYC - 1));
        case (state_r)
            IDLE: begin
                if (|src_req) begin
                    state_s = SETTLE;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: state_s = WRITE;
            WRITE: begin
                if (!usb_txe_n) begin
                    wr_s = 1'b1;
                    if (last_r || at_max_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT1;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            WAIT1:   state_s = WAIT2;
            WAIT2:   state_s = WRITE;
            DONE:    state_s = HOLD;
            HOLD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        ovl_set_s = wr_s && at_max_s && !last_r;
    end

    // State, grant, byte capture and the byte/stall counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= PW'(SRC_CTRL_REGS);
            grant_r     <= {N_SRC{1'b0}};
            busy_r      <= 1'b0;
            byte_r      <= 8'h00;
            last_r      <= 1'b0;
            byte_cnt_r  <= CW'(0);
            stall_cnt_r <= SW'(0);
            done_r      <= {N_SRC{1'b0}};
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == WRITE && state_s == DONE) ? grant_r : {N_SRC{1'b0}};
            if (state_r == IDLE && state_s == SETTLE) begin
                grant_r <= pick_s;
                busy_r  <= 1'b1;
            end
            if (state_r == SETTLE || state_r == WAIT2) begin
                byte_r <= mux_byte_s;
                last_r <= mux_last_s;
            end
            if (state_r == DONE) begin
                grant_r    <= {N_SRC{1'b0}};
                busy_r     <= 1'b0;
                byte_cnt_r <= CW'(0);
                rr_ptr_r   <= (gidx_s == PW'(N_SRC - 1)) ? PW'(0) : gidx_s + PW'(1);
            end else if (wr_s) begin
                byte_cnt_r <= byte_cnt_r + CW'(1);
            end
            if (state_r == WRITE && usb_txe_n) begin
                if (stall_cnt_r != SW'(STALL_CYC)) begin
                    stall_cnt_r <= stall_cnt_r + SW'(1);
                end
            end else if (wr_s || state_r == DONE) begin
                stall_cnt_r <= SW'(0);
            end
        end
    end

    // Sticky supervision flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_flag_r <= 1'b0;
            ovl_flag_r   <= 1'b0;
        end else begin
            if (stall_set_s) begin
                stall_flag_r <= 1'b1;
            end else if (flag_clr) begin
                stall_flag_r <= 1'b0;
            end
            if (ovl_set_s) begin
                ovl_flag_r <= 1'b1;
            end else if (flag_clr) begin
                ovl_flag_r <= 1'b0;
            end
        end
    end

    // Write strobe follows usb_txe_n in the same cycle so the FIFO is never overrun.
    assign usb_wr     = wr_s;
    assign src_rdreq  = wr_s ? grant_r : {N_SRC{1'b0}};
    assign usb_data   = byte_r;
    assign busy       = busy_r;
    assign grant      = grant_r;
    assign src_done   = done_r;
    assign stall_flag = stall_flag_r;
    assign ovl_flag   = ovl_flag_r;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: behavioural sources, a write/done logger
// and hand-computed expectations for each scenario.
module tb_usb_tx_arbiter;
    import usb_tx_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst, usb_txe_n, flag_clr;
    logic [2:0] src_req, src_last, src_rdreq, src_done, grant;
    logic [23:0] src_q;
    logic       usb_wr, busy, stall_flag, ovl_flag;
    logic [7:0] usb_data;

    logic [2:0] src_req2, src_last2, src_rdreq2, src_done2, grant2;
    logic [23:0] src_q2;
    logic       usb_wr2, busy2, stall_flag2, ovl_flag2;
    logic [7:0] usb_data2;

    usb_tx_arbiter #(.N_SRC(3), .MAX_LEN(255), .STALL_CYC(8)) dut (
        .clk(clk), .n_rst(n_rst), .src_req(src_req), .src_q(src_q), .src_last(src_last),
        .src_rdreq(src_rdreq), .src_done(src_done), .usb_txe_n(usb_txe_n), .usb_wr(usb_wr),
        .usb_data(usb_data), .busy(busy), .grant(grant), .stall_flag(stall_flag),
        .ovl_flag(ovl_flag), .flag_clr(flag_clr)
    );

    usb_tx_arbiter #(.N_SRC(3), .MAX_LEN(4), .STALL_CYC(8)) dut_ovl (
        .clk(clk), .n_rst(n_rst), .src_req(src_req2), .src_q(src_q2), .src_last(src_last2),
        .src_rdreq(src_rdreq2), .src_done(src_done2), .usb_txe_n(usb_txe_n), .usb_wr(usb_wr2),
        .usb_data(usb_data2), .busy(busy2), .grant(grant2), .stall_flag(stall_flag2),
        .ovl_flag(ovl_flag2), .flag_clr(flag_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    // Sources: source i emits bytes 64*i+k, k = 0..len-1; packet restarts on reset.
    int         ptr [3];
    int         len [3];
    logic [2:0] pend = 3'b000;
    logic [2:0] start;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 3; i++) ptr[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (src_rdreq[i]) ptr[i] <= src_last[i] ? 0 : ptr[i] + 1;
            end
            pend <= (pend | start) & ~(src_rdreq & src_last);
        end
    end
    assign src_req = pend;
    always_comb begin
        src_q    = 24'h0;
        src_last = 3'b000;
        for (int i = 0; i < 3; i++) begin
            src_q[8*i +: 8] = 8'(64 * i + ptr[i]);
            src_last[i]     = (ptr[i] == len[i] - 1);
        end
    end

    // Overlength instance: source 0 never flags its last byte.
    int   ptr2 = 0;
    logic pend2 = 1'b0;
    logic start2;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr2 <= 0;
        end else begin
            if (src_done2[0]) ptr2 <= 0;
            else if (src_rdreq2[0]) ptr2 <= ptr2 + 1;
            pend2 <= (pend2 | start2) & ~src_done2[0];
        end
    end
    assign src_req2  = {2'b00, pend2};
    assign src_q2    = {16'h0000, 8'(ptr2)};
    assign src_last2 = 3'b000;

    int         cyc = 0;
    logic [7:0] wdat[$];
    int         wsrc[$];
    int         wcyc[$];
    int         dsrc[$];
    logic [7:0] w2dat[$];
    int         n_done2 = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (n_rst) begin
            if (usb_wr) begin
                wdat.push_back(usb_data);
                wsrc.push_back(oh2i(grant));
                wcyc.push_back(cyc);
                check("rdreq_vs_grant", 32'(src_rdreq), 32'(grant));
                check("wr_while_txe_high", 32'(usb_txe_n), 32'd0);
            end else begin
                check("rdreq_without_wr", 32'(src_rdreq), 32'd0);
            end
            if (src_done != 3'b000) dsrc.push_back(oh2i(src_done));
            if (usb_wr2) w2dat.push_back(usb_data2);
            if (src_done2[0]) n_done2++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pkts(input logic [2:0] mask, input int l0, input int l1, input int l2);
        tick();
        len[0] = l0; len[1] = l1; len[2] = l2;
        start = mask;
        tick();
        start = 3'b000;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((pend != 3'b000 || busy) && n < budget);
        check(tag, 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (wdat.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(wdat.size() >= target), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, d, n, s, j;
        int exp_ord [3];
        n_rst = 1'b0; usb_txe_n = 1'b0; flag_clr = 1'b0; start = 3'b000; start2 = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({usb_wr, busy, grant, src_rdreq, src_done, usb_data, stall_flag, ovl_flag}), 32'd0);
        check("reset_outputs_ovl", 32'({usb_wr2, busy2, grant2, src_rdreq2, src_done2, usb_data2, stall_flag2, ovl_flag2}), 32'd0);
        n_rst = 1'b1;
        tick();

        // Single 22-byte packet from the control-register reader.
        m = wdat.size(); d = dsrc.size();
        start_pkts(3'b001, 22, 0, 0);
        wait_quiet("t1_timeout", 400);
        check("t1_count", 32'(wdat.size() - m), 32'd22);
        for (int k = 0; k < 22 && m + k < wdat.size(); k++) begin
            check("t1_data", 32'(wdat[m+k]), 32'(k));
            if (k > 0) check("t1_gap", 32'(wcyc[m+k] - wcyc[m+k-1]), 32'd3);
        end
        check("t1_done_count", 32'(dsrc.size() - d), 32'd1);
        if (dsrc.size() > d) check("t1_done_src", 32'(dsrc[d]), 32'(SRC_CTRL_REGS));
        check("t1_busy_grant", 32'({busy, grant}), 32'd0);

        // All three requesting from rr_ptr=0: order 0,1,2, no interleaving.
        n_rst = 1'b0; tick(); n_rst = 1'b1; tick();
        m = wdat.size(); d = dsrc.size();
        start_pkts(3'b111, 3, 3, 3);
        wait_quiet("t2_timeout", 400);
        check("t2_count", 32'(wdat.size() - m), 32'd9);
        for (int k = 0; k < 9 && m + k < wdat.size(); k++) begin
            s = k / 3; j = k % 3;
            check("t2_src", 32'(wsrc[m+k]), 32'(s));
            check("t2_data", 32'(wdat[m+k]), 32'(64 * s + j));
        end
        exp_ord = '{SRC_CTRL_REGS, SRC_SDI, SRC_CSI};
        check("t2_done_count", 32'(dsrc.size() - d), 32'd3);
        for (int k = 0; k < 3 && d + k < dsrc.size(); k++) check("t2_done_order", 32'(dsrc[d+k]), 32'(exp_ord[k]));

        // Serve source 1 alone (rr_ptr -> 2), then all three: order 2,0,1.
        start_pkts(3'b010, 0, 3, 0);
        wait_quiet("t2b_pre_timeout", 100);
        m = wdat.size(); d = dsrc.size();
        start_pkts(3'b111, 2, 2, 2);
        wait_quiet("t2b_timeout", 400);
        exp_ord = '{2, 0, 1};
        check("t2b_count", 32'(wdat.size() - m), 32'd6);
        for (int k = 0; k < 6 && m + k < wdat.size(); k++) begin
            check("t2b_src", 32'(wsrc[m+k]), 32'(exp_ord[k/2]));
            check("t2b_data", 32'(wdat[m+k]), 32'(64 * exp_ord[k/2] + k % 2));
        end
        for (int k = 0; k < 3 && d + k < dsrc.size(); k++) check("t2b_done_order", 32'(dsrc[d+k]), 32'(exp_ord[k]));

        // Back-pressure: txe_n high through WAIT1/WAIT2 and 5 WRITE cycles at byte 3.
        m = wdat.size();
        start_pkts(3'b010, 0, 6, 0);
        wait_writes("t3_reach_byte2", m + 3, 100);
        @(posedge clk); #1 usb_txe_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 usb_txe_n = 1'b0;
        wait_quiet("t3_timeout", 200);
        check("t3_count", 32'(wdat.size() - m), 32'd6);
        for (int k = 0; k < 6 && m + k < wdat.size(); k++) begin
            check("t3_data", 32'(wdat[m+k]), 32'(8'h40 + k));
            if (k > 0) check("t3_gap", 32'(wcyc[m+k] - wcyc[m+k-1]), (k == 3) ? 32'd8 : 32'd3);
        end
        check("t3_no_stall", 32'(stall_flag), 32'd0);

        // Stall supervision: STALL_CYC=8, txe_n held high for 20 WRITE-phase clocks.
        tick();
        usb_txe_n = 1'b1;
        start_pkts(3'b100, 0, 0, 2);
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        check("t4_busy_seen", 32'(busy), 32'd1);
        for (int c = 1; c <= 20; c++) begin
            tick();
            check($sformatf("t4_stall_c%0d", c), 32'(stall_flag), 32'(c >= 9));
        end
        usb_txe_n = 1'b0;
        wait_quiet("t4_timeout", 100);
        check("t4_stall_sticky", 32'(stall_flag), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("t4_stall_cleared", 32'(stall_flag), 32'd0);
        check("t4_no_ovl", 32'(ovl_flag), 32'd0);

        // Overlength: MAX_LEN=4, source never flags last.
        m = w2dat.size(); d = n_done2;
        tick(); start2 = 1'b1; tick(); start2 = 1'b0;
        n = 0;
        do begin tick(); n++; end while ((pend2 || busy2) && n < 100);
        check("t5_timeout", 32'(n < 100), 32'd1);
        tick();
        check("t5_count", 32'(w2dat.size() - m), 32'd4);
        for (int k = 0; k < 4 && m + k < w2dat.size(); k++) check("t5_data", 32'(w2dat[m+k]), 32'(k));
        check("t5_ovl", 32'(ovl_flag2), 32'd1);
        check("t5_done", 32'(n_done2 - d), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("t5_ovl_cleared", 32'(ovl_flag2), 32'd0);

        // Reset after byte 5 of a source-2 packet: outputs drop at once, packet restarts.
        m = wdat.size();
        start_pkts(3'b100, 0, 0, 10);
        wait_writes("t6_reach_byte5", m + 5, 100);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("t6_reset_outputs", 32'({usb_wr, busy, grant, src_rdreq, src_done, usb_data, stall_flag, ovl_flag}), 32'd0);
        tick(); tick();
        n_rst = 1'b1;
        m = wdat.size();
        wait_quiet("t6_timeout", 200);
        check("t6_count", 32'(wdat.size() - m), 32'd10);
        for (int k = 0; k < 10 && m + k < wdat.size(); k++) check("t6_data", 32'(wdat[m+k]), 32'(8'h80 + k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
